// File: rtl/adder_issue_queue_if.sv
// Bundle of the issue queue's producer, adder and consumer handshakes.
// The slave view is the issue queue itself; the master view is its environment.
interface adder_issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;

  logic          add_start;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_res;
  logic          add_overflow;
  logic          add_ready;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_res;
  logic          out_overflow;

  logic [CW-1:0] count;
  logic          timeout_err;

  modport slave (
    input  in_valid, in_a, in_b,
    input  add_res, add_overflow, add_ready,
    input  out_ready,
    output in_ready,
    output add_start, add_a, add_b,
    output out_valid, out_res, out_overflow,
    output count, timeout_err
  );

  modport master (
    output in_valid, in_a, in_b,
    output add_res, add_overflow, add_ready,
    output out_ready,
    input  in_ready,
    input  add_start, add_a, add_b,
    input  out_valid, out_res, out_overflow,
    input  count, timeout_err
  );
endinterface

// File: rtl/adder_issue_queue.sv
// Operand FIFO plus single-job issue FSM feeding the multi-cycle sequential_adder,
// holding each result on a valid/ready port and flagging a hung adder.
module adder_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  adder_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [WW-1:0] WDOG_ZERO = {WW{1'b0}};
  localparam logic [WW-1:0] WDOG_ONE  = WW'(1'b1);
  // Last WAIT cycle: the count would reach TIMEOUT-1 on this no-ready cycle.
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 2);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [31:0]   mem_a_r [DEPTH];
  logic [31:0]   mem_b_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic [1:0]    state_r;
  logic [WW-1:0] wdog_r;
  logic          out_valid_r;
  logic [31:0]   out_res_r;
  logic          out_overflow_r;
  logic          timeout_err_r;

  logic          push_s;
  logic          pop_s;
  logic [1:0]    state_nxt_s;
  logic [WW-1:0] wdog_nxt_s;
  logic          capture_s;
  logic          expire_s;

  // A full FIFO blocks pushes even when the head is popped in the same cycle.
  assign push_s = bus.in_valid && (count_r != CNT_FULL);
  assign pop_s  = (state_r == ST_IDLE) && (count_r != CNT_ZERO);

  assign bus.in_ready     = (count_r != CNT_FULL);
  assign bus.count        = count_r;
  assign bus.add_start    = pop_s;
  assign bus.add_a        = mem_a_r[rd_ptr_r];
  assign bus.add_b        = mem_b_r[rd_ptr_r];
  assign bus.out_valid    = out_valid_r;
  assign bus.out_res      = out_res_r;
  assign bus.out_overflow = out_overflow_r;
  assign bus.timeout_err  = timeout_err_r;

  // Next-state, watchdog and capture decisions for the issue FSM.
  always_comb begin
    state_nxt_s = state_r;
    wdog_nxt_s  = wdog_r;
    capture_s   = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_WAIT;
          wdog_nxt_s  = WDOG_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.add_ready) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (wdog_r == WDOG_LAST) begin
          expire_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          wdog_nxt_s  = wdog_r + WDOG_ONE;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        wdog_nxt_s  = WDOG_ZERO;
      end
    endcase
  end

  // Circular operand storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a_r[i] <= 32'h0000_0000;
        mem_b_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_a_r[wr_ptr_r] <= bus.in_a;
        mem_b_r[wr_ptr_r] <= bus.in_b;
        wr_ptr_r          <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r          <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state, watchdog, captured result and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      wdog_r         <= WDOG_ZERO;
      out_valid_r    <= 1'b0;
      out_res_r      <= 32'h0000_0000;
      out_overflow_r <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wdog_r      <= wdog_nxt_s;
      out_valid_r <= (state_nxt_s == ST_HOLD);
      if (capture_s) begin
        out_res_r      <= bus.add_res;
        out_overflow_r <= bus.add_overflow;
      end else begin
        out_res_r      <= out_res_r;
        out_overflow_r <= out_overflow_r;
      end
      timeout_err_r <= timeout_err_r | expire_s;
    end
  end
endmodule

// File: tb/tb_adder_issue_queue.sv
// Scoreboard bench for adder_issue_queue with a 5-cycle sequential adder model.
module tb_adder_issue_queue;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_q = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  op_t         issue_q [$];
  logic [32:0] result_q [$];

  int          mdl_phase = 0;
  logic        mdl_hung  = 1'b0;
  logic [32:0] mdl_sum   = 33'h0;
  logic        hang_next = 1'b0;

  adder_issue_queue_if #(.DEPTH(DEPTH)) bus();

  adder_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_q <= rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Adder model plus issue/result scoreboard, evaluated 1ns after each falling edge.
  always begin
    op_t         op;
    logic [32:0] exp_r;
    @(negedge clk);
    #1;
    if (rst_q) begin
      mdl_phase        = 0;
      hang_next        = 1'b0;
      bus.add_ready    = 1'b0;
      bus.add_res      = 32'h0;
      bus.add_overflow = 1'b0;
      issue_q.delete();
      result_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("result_expected", 32'(result_q.size() != 0), 32'd1);
        if (result_q.size() != 0) begin
          exp_r = result_q.pop_front();
          chk("out_res", bus.out_res, exp_r[31:0]);
          chk("out_overflow", 32'(bus.out_overflow), 32'(exp_r[32]));
        end
      end
      bus.add_ready    = 1'b0;
      bus.add_res      = $urandom();
      bus.add_overflow = (($urandom() & 32'h1) != 32'h0);
      if (mdl_phase == 5) begin
        if (!mdl_hung) begin
          bus.add_ready    = 1'b1;
          bus.add_res      = mdl_sum[31:0];
          bus.add_overflow = mdl_sum[32];
        end
        mdl_phase = 6;
      end else if (mdl_phase == 6) begin
        mdl_phase = 0;
      end else if (mdl_phase != 0) begin
        mdl_phase = mdl_phase + 1;
      end
      if (bus.add_start) begin
        chk("start_adder_idle", 32'(mdl_phase == 0), 32'd1);
        chk("start_has_job", 32'(issue_q.size() != 0), 32'd1);
        if (issue_q.size() != 0) begin
          op = issue_q.pop_front();
          chk("add_a", bus.add_a, op.a);
          chk("add_b", bus.add_b, op.b);
          mdl_sum   = {1'b0, op.a} + {1'b0, op.b};
          mdl_hung  = hang_next;
          hang_next = 1'b0;
          if (!mdl_hung) result_q.push_back(mdl_sum);
          mdl_phase = 1;
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    logic acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int n = 0; n < 100 && !acc; n++) begin
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) issue_q.push_back({a, b});
      else @(negedge clk);
    end
    chk("push_accepted", 32'(acc), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    logic done = 1'b0;
    for (int n = 0; n < 800 && !done; n++) begin
      @(negedge clk);
      done = (issue_q.size() == 0) && (result_q.size() == 0) && !bus.out_valid &&
             (mdl_phase == 0) && (bus.count == 3'd0);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic seen;
    logic stop;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_add_start", 32'(bus.add_start), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_res", bus.out_res, 32'h0);
    chk("rst_out_overflow", 32'(bus.out_overflow), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("rst_add_a", bus.add_a, 32'h0);
    chk("rst_add_b", bus.add_b, 32'h0);

    // Single job latency: push t, start t+1, out_valid t+7
    bus.out_ready = 1'b1;
    push(32'h0000_00FF, 32'h0000_0001);
    chk("lat_start", 32'(bus.add_start), 32'd1);
    repeat (5) @(negedge clk);
    chk("lat_not_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_out_res", bus.out_res, 32'h0000_0100);
    chk("lat_out_overflow", 32'(bus.out_overflow), 32'd0);
    drain("drain_lat");

    // Carry-out wraps
    push(32'hFFFF_FFFF, 32'h0000_0001);
    drain("drain_carry");

    // Backpressure in HOLD while the FIFO fills
    bus.out_ready = 1'b0;
    push(32'h0000_0000, 32'h0000_0010);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk("hold_reached", 32'(seen), 32'd1);
    fork
      begin
        for (int i = 1; i <= 5; i++) push(32'(i), 32'h0000_0010);
      end
      begin
        for (int k = 0; k < 10; k++) begin
          chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_out_res", bus.out_res, 32'h0000_0010);
          chk("bp_no_start", 32'(bus.add_start), 32'd0);
          @(negedge clk);
        end
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_restart", 32'(bus.add_start), 32'd1);
      end
    join
    drain("drain_full");

    // Watchdog: first job hangs, second completes
    hang_next = 1'b1;
    push(32'h0000_1234, 32'h0000_0001);
    chk("to_start", 32'(bus.add_start), 32'd1);
    push(32'h0000_0055, 32'h0000_0066);
    for (int k = 1; k <= 16; k++) begin
      chk("to_no_out", 32'(bus.out_valid), 32'd0);
      if (k == 15) chk("to_not_yet", 32'(bus.timeout_err), 32'd0);
      if (k == 16) begin
        chk("to_flag", 32'(bus.timeout_err), 32'd1);
        chk("to_next_start", 32'(bus.add_start), 32'd1);
      end
      if (k < 16) @(negedge clk);
    end
    drain("drain_timeout");
    chk("to_sticky", 32'(bus.timeout_err), 32'd1);

    // Randomized traffic with random consumer backpressure
    stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push(pick(), pick());
        end
        stop = 1'b1;
      end
      begin
        for (int n = 0; n < 5000 && !stop; n++) begin
          bus.out_ready = ($urandom_range(0, 1) != 0);
          @(negedge clk);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("drain_random");

    // Reset in WAIT with three jobs queued
    push(32'h0000_0001, 32'h0000_0002);
    push(32'h0000_0003, 32'h0000_0004);
    push(32'h0000_0005, 32'h0000_0006);
    push(32'h0000_0007, 32'h0000_0008);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      seen = seen | bus.add_start | bus.out_valid;
      @(negedge clk);
    end
    chk("mid_rst_quiet", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
